// File: rtl/rvfi_reorder_pkg.sv
// Shared types and helpers for the RVFI reorder buffer: packet width,
// packet field offsets and the protocol error codes.
package rvfi_reorder_pkg;

    // Cause of the first protocol error seen since reset.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_STALE    = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_COLLIDE  = 2'd3
    } err_code_e;

    // Packet fields, listed from the LSB upward.
    typedef enum logic [4:0] {
        F_MEM_WDATA  = 5'd0,
        F_MEM_RDATA  = 5'd1,
        F_MEM_WMASK  = 5'd2,
        F_MEM_RMASK  = 5'd3,
        F_MEM_ADDR   = 5'd4,
        F_PC_WDATA   = 5'd5,
        F_PC_RDATA   = 5'd6,
        F_RD_WDATA   = 5'd7,
        F_RD_ADDR    = 5'd8,
        F_RS2_RDATA  = 5'd9,
        F_RS1_RDATA  = 5'd10,
        F_RS2_ADDR   = 5'd11,
        F_RS1_ADDR   = 5'd12,
        F_INTR       = 5'd13,
        F_HALT       = 5'd14,
        F_TRAP       = 5'd15,
        F_INSN       = 5'd16
    } rvfi_field_e;

    // Flat packet width: insn + 3 flags + 3 register addresses + 8 XLEN words + 2 byte masks.
    function automatic int unsigned pkt_w(input int unsigned xlen, input int unsigned ilen);
        return ilen + 32'd18 + 32'd8 * xlen + xlen / 32'd4;
    endfunction

    // Bit offset of the LSB of a packet field.
    function automatic int unsigned field_off(input rvfi_field_e f, input int unsigned xlen);
        int unsigned q;
        q = xlen / 32'd4;
        case (f)
            F_MEM_WDATA: return 32'd0;
            F_MEM_RDATA: return xlen;
            F_MEM_WMASK: return 32'd2 * xlen;
            F_MEM_RMASK: return 32'd2 * xlen + xlen / 32'd8;
            F_MEM_ADDR:  return 32'd2 * xlen + q;
            F_PC_WDATA:  return 32'd3 * xlen + q;
            F_PC_RDATA:  return 32'd4 * xlen + q;
            F_RD_WDATA:  return 32'd5 * xlen + q;
            F_RD_ADDR:   return 32'd6 * xlen + q;
            F_RS2_RDATA: return 32'd6 * xlen + q + 32'd5;
            F_RS1_RDATA: return 32'd7 * xlen + q + 32'd5;
            F_RS2_ADDR:  return 32'd8 * xlen + q + 32'd5;
            F_RS1_ADDR:  return 32'd8 * xlen + q + 32'd10;
            F_INTR:      return 32'd8 * xlen + q + 32'd15;
            F_HALT:      return 32'd8 * xlen + q + 32'd16;
            F_TRAP:      return 32'd8 * xlen + q + 32'd17;
            F_INSN:      return 32'd8 * xlen + q + 32'd18;
            default:     return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/rvfi_reorder_buffer_slots.sv
// Reorder window storage: DEPTH slots of {occupied, order, packet} with one
// write port and one read/clear port (the read port sits at the head index).
module rvfi_reorder_slots #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ORDER_W = 64,
    parameter int unsigned PKT_W   = 314,
    localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               wr_en_i,
    input  logic [IDX_W-1:0]   wr_idx_i,
    input  logic [ORDER_W-1:0] wr_order_i,
    input  logic [PKT_W-1:0]   wr_pkt_i,
    output logic               wr_occ_o,
    input  logic [IDX_W-1:0]   rd_idx_i,
    input  logic               clr_i,
    output logic               rd_occ_o,
    output logic [ORDER_W-1:0] rd_order_o,
    output logic [PKT_W-1:0]   rd_pkt_o
);

    logic [DEPTH-1:0]   occ_q;
    logic [DEPTH-1:0]   occ_d;
    logic [DEPTH-1:0]   clr_mask_s;
    logic [DEPTH-1:0]   set_mask_s;
    logic [ORDER_W-1:0] order_q [DEPTH];
    logic [PKT_W-1:0]   pkt_q   [DEPTH];

    // Occupancy update: a same-slot write wins over the clear so an emit and refill can coincide.
    always_comb begin
        clr_mask_s = clr_i   ? (DEPTH'(1'b1) << rd_idx_i) : {DEPTH{1'b0}};
        set_mask_s = wr_en_i ? (DEPTH'(1'b1) << wr_idx_i) : {DEPTH{1'b0}};
        occ_d      = (occ_q & ~clr_mask_s) | set_mask_s;
    end

    // Occupied-bit register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            occ_q <= {DEPTH{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    // Slot payload storage, written only on an accepted packet.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                order_q[i] <= {ORDER_W{1'b0}};
                pkt_q[i]   <= {PKT_W{1'b0}};
            end
        end else if (wr_en_i) begin
            order_q[wr_idx_i] <= wr_order_i;
            pkt_q[wr_idx_i]   <= wr_pkt_i;
        end
    end

    assign wr_occ_o   = occ_q[wr_idx_i];
    assign rd_occ_o   = occ_q[rd_idx_i];
    assign rd_order_o = order_q[rd_idx_i];
    assign rd_pkt_o   = pkt_q[rd_idx_i];

endmodule

// File: rtl/rvfi_reorder_buffer.sv
// RVFI reorder buffer: accepts out-of-order retirement packets tagged with
// rvfi_order and re-emits them one per cycle in strictly increasing order.
module rvfi_reorder_buffer
    import rvfi_reorder_pkg::*;
#(
    parameter int unsigned  XLEN        = 32,
    parameter int unsigned  ILEN        = 32,
    parameter int unsigned  DEPTH       = 8,
    parameter int unsigned  ORDER_W     = 64,
    parameter logic [63:0]  CHECK_ORDER = 64'd0,
    localparam int unsigned PKT_W       = pkt_w(XLEN, ILEN)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               in_valid,
    input  logic [ORDER_W-1:0] in_order,
    input  logic [PKT_W-1:0]   in_pkt,
    output logic               out_valid,
    output logic [ORDER_W-1:0] out_order,
    output logic [PKT_W-1:0]   out_pkt,
    output logic               out_check,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam int unsigned        IDX_W   = $clog2(DEPTH);
    localparam logic [ORDER_W-1:0] DEPTH_O = ORDER_W'(DEPTH);
    localparam logic [ORDER_W-1:0] CHECK_O = CHECK_ORDER[ORDER_W-1:0];
    localparam logic [ORDER_W-1:0] ONE_O   = ORDER_W'(1'b1);

    logic [ORDER_W-1:0] head_q, head_d;
    logic [ORDER_W-1:0] dist_s;
    logic [IDX_W-1:0]   wr_idx_s, rd_idx_s;
    logic               wr_en_s, wr_occ_s;
    logic               rd_occ_s, clr_s;
    logic [ORDER_W-1:0] rd_order_s;
    logic [PKT_W-1:0]   rd_pkt_s;
    err_code_e          cause_s;

    logic               out_valid_q, out_valid_d;
    logic [ORDER_W-1:0] out_order_q, out_order_d;
    logic [PKT_W-1:0]   out_pkt_q, out_pkt_d;
    logic               out_check_q, out_check_d;
    logic               err_q, err_d;
    err_code_e          err_code_q, err_code_d;

    rvfi_reorder_slots #(
        .DEPTH   (DEPTH),
        .ORDER_W (ORDER_W),
        .PKT_W   (PKT_W)
    ) u_slots (
        .clock      (clock),
        .resetn     (resetn),
        .wr_en_i    (wr_en_s),
        .wr_idx_i   (wr_idx_s),
        .wr_order_i (in_order),
        .wr_pkt_i   (in_pkt),
        .wr_occ_o   (wr_occ_s),
        .rd_idx_i   (rd_idx_s),
        .clr_i      (clr_s),
        .rd_occ_o   (rd_occ_s),
        .rd_order_o (rd_order_s),
        .rd_pkt_o   (rd_pkt_s)
    );

    // Accept classification; the modular distance's MSB marks an order behind head.
    always_comb begin
        dist_s   = in_order - head_q;
        wr_idx_s = in_order[IDX_W-1:0];
        cause_s  = ERR_NONE;
        wr_en_s  = 1'b0;
        if (in_valid) begin
            if (dist_s[ORDER_W-1]) begin
                cause_s = ERR_STALE;
            end else if (dist_s >= DEPTH_O) begin
                cause_s = ERR_OVERFLOW;
            end else if (wr_occ_s) begin
                cause_s = ERR_COLLIDE;
            end else begin
                wr_en_s = 1'b1;
            end
        end else begin
            cause_s = ERR_NONE;
            wr_en_s = 1'b0;
        end
    end

    // Emit: drain the head slot if it was occupied at the start of the cycle.
    always_comb begin
        rd_idx_s    = head_q[IDX_W-1:0];
        clr_s       = rd_occ_s;
        head_d      = head_q;
        out_valid_d = 1'b0;
        out_order_d = out_order_q;
        out_pkt_d   = out_pkt_q;
        out_check_d = 1'b0;
        if (rd_occ_s) begin
            head_d      = head_q + ONE_O;
            out_valid_d = 1'b1;
            out_order_d = rd_order_s;
            out_pkt_d   = rd_pkt_s;
            out_check_d = (head_q == CHECK_O);
        end else begin
            head_d      = head_q;
            out_valid_d = 1'b0;
        end
    end

    // Sticky error: only the first cause is captured.
    always_comb begin
        err_d      = err_q;
        err_code_d = err_code_q;
        if (!err_q && (cause_s != ERR_NONE)) begin
            err_d      = 1'b1;
            err_code_d = cause_s;
        end else begin
            err_d      = err_q;
            err_code_d = err_code_q;
        end
    end

    // Head pointer, output and error registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            head_q      <= {ORDER_W{1'b0}};
            out_valid_q <= 1'b0;
            out_order_q <= {ORDER_W{1'b0}};
            out_pkt_q   <= {PKT_W{1'b0}};
            out_check_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
            out_order_q <= out_order_d;
            out_pkt_q   <= out_pkt_d;
            out_check_q <= out_check_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_order = out_order_q;
    assign out_pkt   = out_pkt_q;
    assign out_check = out_check_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_rvfi_reorder_buffer.sv
// Self-checking bench: a 64-bit-order instance (CHECK_ORDER=5) and a 4-bit-order
// instance (CHECK_ORDER=15) are compared every cycle against a queue-based model.
module tb_rvfi_reorder_buffer;
    import rvfi_reorder_pkg::*;

    localparam int unsigned PKT_W = pkt_w(32'd32, 32'd32);
    typedef logic [PKT_W-1:0] pkt_t;

    typedef struct {
        int              inst;
        longint unsigned ord;
        pkt_t            pkt;
    } ent_t;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;

    logic        m_valid = 1'b0;
    logic [63:0] m_order = 64'd0;
    pkt_t        m_pkt   = '0;
    logic        m_ov, m_oc, m_err;
    logic [63:0] m_oo;
    pkt_t        m_op;
    logic [1:0]  m_code;

    logic        w_valid = 1'b0;
    logic [3:0]  w_order = 4'd0;
    pkt_t        w_pkt   = '0;
    logic        w_ov, w_oc, w_err;
    logic [3:0]  w_oo;
    pkt_t        w_op;
    logic [1:0]  w_code;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, per instance.
    ent_t            pend[$];
    longint unsigned mhead[2];
    bit              ev[2];
    longint unsigned eo[2];
    pkt_t            ep[2];
    bit              ec[2];
    bit              ee[2];
    logic [1:0]      ecode[2];

    rvfi_reorder_buffer #(
        .XLEN(32), .ILEN(32), .DEPTH(8), .ORDER_W(64), .CHECK_ORDER(64'd5)
    ) u_dut (
        .clock(clock), .resetn(resetn),
        .in_valid(m_valid), .in_order(m_order), .in_pkt(m_pkt),
        .out_valid(m_ov), .out_order(m_oo), .out_pkt(m_op), .out_check(m_oc),
        .err(m_err), .err_code(m_code)
    );

    rvfi_reorder_buffer #(
        .XLEN(32), .ILEN(32), .DEPTH(8), .ORDER_W(4), .CHECK_ORDER(64'd15)
    ) u_wrap (
        .clock(clock), .resetn(resetn),
        .in_valid(w_valid), .in_order(w_order), .in_pkt(w_pkt),
        .out_valid(w_ov), .out_order(w_oo), .out_pkt(w_op), .out_check(w_oc),
        .err(w_err), .err_code(w_code)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t rand_pkt();
        logic [319:0] t;
        for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom();
        return t[PKT_W-1:0];
    endfunction

    task automatic model_reset();
        pend.delete();
        for (int k = 0; k < 2; k++) begin
            mhead[k] = 64'd0; ev[k] = 1'b0; eo[k] = 64'd0; ep[k] = '0;
            ec[k] = 1'b0; ee[k] = 1'b0; ecode[k] = 2'd0;
        end
    endtask

    // One clock edge of the ideal behaviour: emit order==head if held, classify the arrival.
    task automatic model_step(input int k, input bit v, input longint unsigned ord, input pkt_t p);
        longint unsigned h0, d, msk, half, chko;
        int              hit;
        bit              dup;
        logic [1:0]      cause;
        msk  = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hF;
        half = (k == 0) ? 64'h8000_0000_0000_0000 : 64'd8;
        chko = (k == 0) ? 64'd5 : 64'd15;
        h0 = mhead[k];
        hit = -1;
        dup = 1'b0;
        foreach (pend[i]) begin
            if (pend[i].inst == k && pend[i].ord == h0) hit = i;
            if (pend[i].inst == k && pend[i].ord == ord) dup = 1'b1;
        end
        cause = 2'd0;
        if (v) begin
            d = (ord - h0) & msk;
            if (d >= half)      cause = 2'd1;
            else if (d >= 64'd8) cause = 2'd2;
            else if (dup)        cause = 2'd3;
        end
        if (hit >= 0) begin
            ev[k] = 1'b1;
            eo[k] = h0;
            ep[k] = pend[hit].pkt;
            ec[k] = (h0 == chko);
            pend.delete(hit);
            mhead[k] = (h0 + 64'd1) & msk;
        end else begin
            ev[k] = 1'b0;
            ec[k] = 1'b0;
        end
        if (v && cause == 2'd0) pend.push_back('{inst: k, ord: ord, pkt: p});
        if (cause != 2'd0 && !ee[k]) begin
            ee[k] = 1'b1;
            ecode[k] = cause;
        end
    endtask

    function automatic bit has_pending(input int k);
        foreach (pend[i]) if (pend[i].inst == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare_all();
        chk("m.valid", m_ov, ev[0]);   chk("m.order", m_oo, eo[0]);
        chk("m.pkt",   m_op, ep[0]);   chk("m.check", m_oc, ec[0]);
        chk("m.err",   m_err, ee[0]);  chk("m.code",  m_code, ecode[0]);
        chk("w.valid", w_ov, ev[1]);   chk("w.order", w_oo, eo[1]);
        chk("w.pkt",   w_op, ep[1]);   chk("w.check", w_oc, ec[1]);
        chk("w.err",   w_err, ee[1]);  chk("w.code",  w_code, ecode[1]);
    endtask

    task automatic tick();
        model_step(0, m_valid, m_order, m_pkt);
        model_step(1, w_valid, 64'(w_order), w_pkt);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_m(input longint unsigned o);
        m_valid = 1'b1; m_order = o; m_pkt = rand_pkt();
        tick();
        m_valid = 1'b0;
    endtask

    task automatic send_w(input longint unsigned o);
        w_valid = 1'b1; w_order = o[3:0]; w_pkt = rand_pkt();
        tick();
        w_valid = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (has_pending(k) && n < 40) begin
            tick();
            n++;
        end
        chk("drain.bound", has_pending(k), 1'b0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic rand_block(input int k);
        int              perm[8];
        int              j, t;
        longint unsigned base;
        for (int i = 0; i < 8; i++) perm[i] = i;
        for (int i = 7; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        base = mhead[k];
        for (int i = 0; i < 8; i++) begin
            if (k == 0) send_m(base + longint'(perm[i]));
            else        send_w((base + longint'(perm[i])) & 64'hF);
            idle($urandom_range(2, 0));
        end
        drain(k);
    endtask

    initial begin
        int              npulse;
        longint unsigned pulse_ord;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        resetn = 1'b1;

        // In-order stream 0..9 with latency and check-pulse accounting.
        npulse = 0;
        pulse_ord = 64'd0;
        send_m(64'd0);
        chk("lat.edge1.valid", m_ov, 1'b0);
        send_m(64'd1);
        chk("lat.edge2.valid", m_ov, 1'b1);
        chk("lat.edge2.order", m_oo, 64'd0);
        for (int o = 2; o < 13; o++) begin
            if (o < 10) send_m(64'(o));
            else        tick();
            if (m_oc) begin
                npulse++;
                pulse_ord = m_oo;
            end
        end
        chk("pulse.count", npulse, 1);
        chk("pulse.order", pulse_ord, 64'd5);
        chk("inorder.err", m_err, 1'b0);

        // Out-of-order arrival 12,11,10 released as 10,11,12.
        send_m(64'd12);
        send_m(64'd11);
        chk("ooo.hold", m_ov, 1'b0);
        send_m(64'd10);
        chk("ooo.hold2", m_ov, 1'b0);
        tick(); chk("ooo.first", m_oo, 64'd10);
        tick(); chk("ooo.second", m_oo, 64'd11);
        tick(); chk("ooo.third", m_oo, 64'd12);
        idle(2);

        // Reset while three slots are occupied.
        send_m(64'd14);
        send_m(64'd15);
        send_m(64'd16);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst.valid", m_ov, 1'b0);
        chk("rst.order", m_oo, 64'd0);
        chk("rst.pkt",   m_op, '0);
        chk("rst.check", m_oc, 1'b0);
        model_reset();
        @(posedge clock);
        #1;
        compare_all();
        #2;
        resetn = 1'b1;
        send_m(64'd0);
        chk("rst.after.edge1", m_ov, 1'b0);
        tick();
        chk("rst.after.valid", m_ov, 1'b1);
        chk("rst.after.order", m_oo, 64'd0);

        // Errors: overflow first, then a later collision must not change the code.
        do_reset();
        send_m(64'd9);
        chk("err.ovf.flag", m_err, 1'b1);
        chk("err.ovf.code", m_code, 2'd2);
        send_m(64'd3);
        send_m(64'd3);
        chk("err.sticky.code", m_code, 2'd2);
        idle(2);
        do_reset();
        send_m(64'd0);
        chk("err.none", m_err, 1'b0);
        send_m(64'd0);
        chk("err.col.flag", m_err, 1'b1);
        chk("err.col.code", m_code, 2'd3);
        idle(2);
        do_reset();

        // Randomized shuffled windows on the wide instance.
        for (int b = 0; b < 20; b++) rand_block(0);
        chk("rand.m.err", m_err, 1'b0);

        // Wrap on the 4-bit instance: preset head to 14, then 14,15,0,1.
        for (int o = 0; o < 14; o++) send_w(64'(o));
        drain(1);
        idle(1);
        send_w(64'd14);
        send_w(64'd15);
        chk("wrap.o14", w_oo, 4'd14);
        send_w(64'd0);
        chk("wrap.o15", w_oo, 4'd15);
        chk("wrap.check15", w_oc, 1'b1);
        send_w(64'd1);
        chk("wrap.o0", w_oo, 4'd0);
        tick();
        chk("wrap.o1", w_oo, 4'd1);
        chk("wrap.err", w_err, 1'b0);
        for (int b = 0; b < 10; b++) rand_block(1);
        chk("rand.w.err", w_err, 1'b0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
